// File: rtl/hc05_uart_pkg.sv
// Shared types and helpers for the HC-05 UART receive path.
// The PARITY state exists only when HC05_RX_PARITY_EN is defined.
package hc05_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef HC05_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Clock cycles per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hc05_rx_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word.
// Shared between the HC-05 receive and transmit paths.
module hc05_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;
    logic             valid_r;
    logic             do_rd_s;
    logic             do_wr_s;

    assign full    = (count_r == CW'(DEPTH));
    assign do_rd_s = rd_en && (count_r != {CW{1'b0}});
    // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
    assign do_wr_s = wr_en && (!full || do_rd_s);

    // Next occupancy and next head word.
    always_comb begin
        count_next_s = count_r;
        head_next_s  = head_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (do_wr_s && (count_r == {CW{1'b0}})) begin
            head_next_s = wr_data;
        end else if (do_rd_s && do_wr_s && (count_r == CW'(1))) begin
            head_next_s = wr_data;
        end else if (do_rd_s && (count_r > CW'(1))) begin
            head_next_s = mem_r[AW'(rd_ptr_r + AW'(1))];
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array, no reset needed since the head register masks stale words.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= AW'(wr_ptr_r + AW'(1));
            end
            if (do_rd_s) begin
                rd_ptr_r <= AW'(rd_ptr_r + AW'(1));
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    assign rd_data = head_r;
    assign valid   = valid_r;
    assign count   = count_r;

endmodule

// File: rtl/hc05_uart_rx.sv
// HC-05 UART receiver: 16x oversampled 8N1 (8E1 with HC05_RX_PARITY_EN),
// FWFT receive FIFO and sticky framing/overrun/parity flags.
module hc05_uart_rx
    import hc05_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          framing_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    input  logic                          err_clr
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    logic [1:0]           sync_r;
    logic                 rxs_s;
    logic [DIV_W-1:0]     div_cnt_r;
    logic                 tick_s;
    rx_state_t            state_r;
    logic [OS_W-1:0]      os_cnt_r;
    logic [2:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 push_r;
    logic                 mid_s;
    logic                 end_s;
    logic                 stop_sample_s;
    logic                 frame_set_s;
    logic                 parity_bad_s;
    logic                 fifo_full_s;
    logic                 framing_err_r;
    logic                 overrun_err_r;

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd};
        end
    end
    assign rxs_s = sync_r[1];

    // Free-running oversample tick divider.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_W'(DIV - 1)) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end
    assign tick_s = (div_cnt_r == DIV_W'(DIV - 1));

    assign mid_s         = (os_cnt_r == OS_W'(OVERSAMPLE / 2 - 1));
    assign end_s         = (os_cnt_r == OS_W'(OVERSAMPLE - 1));
    assign stop_sample_s = (state_r == STOP) && tick_s && end_s;
    assign frame_set_s   = stop_sample_s && !rxs_s;

`ifdef HC05_RX_PARITY_EN
    logic par_r;
    assign parity_bad_s = even_parity(shreg_r) ^ par_r;
`else
    assign parity_bad_s = 1'b0;
`endif

    // Frame FSM: after the half-bit start check every sample lands mid-bit.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_r   <= IDLE;
            os_cnt_r  <= {OS_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shreg_r   <= {DATA_BITS{1'b0}};
            push_r    <= 1'b0;
`ifdef HC05_RX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            push_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick_s && !rxs_s) begin
                        state_r  <= START;
                        os_cnt_r <= {OS_W{1'b0}};
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (mid_s) begin
                            os_cnt_r  <= {OS_W{1'b0}};
                            bit_cnt_r <= 3'd0;
                            state_r   <= rxs_s ? IDLE : DATA;
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (end_s) begin
                            os_cnt_r <= {OS_W{1'b0}};
                            shreg_r  <= {rxs_s, shreg_r[DATA_BITS-1:1]};
                            if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
`ifdef HC05_RX_PARITY_EN
                                state_r <= PARITY;
`else
                                state_r <= STOP;
`endif
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
`ifdef HC05_RX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        if (end_s) begin
                            os_cnt_r <= {OS_W{1'b0}};
                            par_r    <= rxs_s;
                            state_r  <= STOP;
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        if (end_s) begin
                            os_cnt_r <= {OS_W{1'b0}};
                            if (!rxs_s) begin
                                state_r <= BREAK;
                            end else begin
                                state_r <= IDLE;
                                push_r  <= !parity_bad_s;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
                BREAK: begin
                    if (rxs_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    hc05_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .wr_en   (push_r),
        .wr_data (shreg_r),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .valid   (rx_valid),
        .count   (rx_count),
        .full    (fifo_full_s)
    );

    // Sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            framing_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            framing_err_r <= frame_set_s | (framing_err_r & !err_clr);
            overrun_err_r <= (push_r && fifo_full_s && !(rx_valid && rx_ready))
                           | (overrun_err_r & !err_clr);
        end
    end

`ifdef HC05_RX_PARITY_EN
    logic parity_err_r;

    // Parity flag is raised on a good stop bit whose frame failed the check.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= (stop_sample_s && rxs_s && parity_bad_s)
                          | (parity_err_r & !err_clr);
        end
    end
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign framing_err = framing_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_hc05_uart_rx.sv
// Scoreboard bench for hc05_uart_rx at 16 clocks per bit (DIV=1).
// Build with HC05_RX_PARITY_EN to add the 8E1 frame checks.
module tb_hc05_uart_rx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] rx_count;
    logic       framing_err;
    logic       overrun_err;
    logic       parity_err;
    logic       err_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    hc05_uart_rx #(
        .CLK_HZ     (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_n),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .framing_err   (framing_err),
        .overrun_err   (overrun_err),
        .parity_err    (parity_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial frame; stop_low > 0 holds the stop bit low that many clocks.
    task automatic send_byte(input logic [7:0] b, input int stop_low, input logic par_flip);
        rxd = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) tick();
        end
`ifdef HC05_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (16) tick();
`endif
        if (stop_low > 0) begin
            rxd = 1'b0;
            repeat (stop_low) tick();
        end
        rxd = 1'b1;
        repeat (16) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rx_ready = 1'b1;
        while (rx_valid && n < 100) begin
            tick();
            n++;
        end
        rx_ready = 1'b0;
        check("drain_done", int'(rx_valid), 0);
    endtask

    // Monitor: compares the head byte on every accepted handshake.
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", rx_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (4) tick();
        check("reset_valid", int'(rx_valid), 0);
        check("reset_data", int'(rx_data), 8'h00);
        check("reset_count", int'(rx_count), 0);
        check("reset_errs", int'({framing_err, overrun_err, parity_err}), 0);
        reset_n = 1'b1;
        repeat (20) tick();

        // 1: single byte held in the FIFO
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 0, 1'b0);
        check("t1_valid", int'(rx_valid), 1);
        check("t1_data", int'(rx_data), 8'hA5);
        check("t1_count", int'(rx_count), 1);
        drain();

        // 2: short glitch on the line
        rxd = 1'b0;
        repeat (5) tick();
        rxd = 1'b1;
        repeat (40) tick();
        check("t2_count", int'(rx_count), 0);
        check("t2_errs", int'({framing_err, overrun_err, parity_err}), 0);

        // 3: framing error then recovery
        send_byte(8'h3C, 40, 1'b0);
        repeat (10) tick();
        check("t3_framing", int'(framing_err), 1);
        check("t3_count", int'(rx_count), 0);
        exp_q.push_back(8'h11);
        send_byte(8'h11, 0, 1'b0);
        check("t3_next_count", int'(rx_count), 1);
        drain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_cleared", int'(framing_err), 0);

        // 4: overrun with 17 bytes
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), 0, 1'b0);
        end
        check("t4_count", int'(rx_count), 16);
        check("t4_overrun", int'(overrun_err), 1);
        check("t4_head", int'(rx_data), 8'h00);
        drain();
        check("t4_empty_count", int'(rx_count), 0);
        check("t4_hold_data", int'(rx_data), 8'h0F);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_cleared", int'(overrun_err), 0);

        // 5: clear held across the framing error; set must win
        seen = 1'b0;
        err_clr = 1'b1;
        fork
            send_byte(8'h3C, 40, 1'b0);
            begin
                for (int i = 0; i < 400; i++) begin
                    tick();
                    if (framing_err) begin
                        seen = 1'b1;
                        break;
                    end
                end
                err_clr = 1'b0;
            end
        join
        check("t5_set_wins", int'(seen), 1);
        check("t5_still_set", int'(framing_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("t5_clear", int'(framing_err), 0);

        // reset mid-frame: no push, no error
        fork
            send_byte(8'hFF, 0, 1'b0);
            begin
                repeat (50) tick();
                reset_n = 1'b0;
                repeat (2) tick();
                reset_n = 1'b1;
            end
        join
        repeat (20) tick();
        check("rst_mid_count", int'(rx_count), 0);
        check("rst_mid_errs", int'({framing_err, overrun_err, parity_err}), 0);

`ifdef HC05_RX_PARITY_EN
        // 6: even parity, bad then good
        send_byte(8'h01, 0, 1'b1);
        repeat (5) tick();
        check("t6_parity_err", int'(parity_err), 1);
        check("t6_no_push", int'(rx_count), 0);
        exp_q.push_back(8'h01);
        send_byte(8'h01, 0, 1'b0);
        check("t6_push", int'(rx_count), 1);
        drain();
`endif

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
